// File: rtl/quad_mapper.sv
// quad_mapper: streams a 2^LOG2_W x 2^LOG2_H source image onto a screen
// quadrilateral A-B-C-D using fixed-point bilinear edge and span stepping.
module quad_mapper #(
    parameter int LOG2_W    = 6,
    parameter int LOG2_H    = 6,
    parameter int PIX_BITS  = 18,
    parameter int X_BITS    = 10,
    parameter int Y_BITS    = 9,
    parameter int FRAC_BITS = 8,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                frame_start,
    input  logic [X_BITS-1:0]   ax,
    input  logic [X_BITS-1:0]   bx,
    input  logic [X_BITS-1:0]   cx,
    input  logic [X_BITS-1:0]   dx,
    input  logic [Y_BITS-1:0]   ay,
    input  logic [Y_BITS-1:0]   by,
    input  logic [Y_BITS-1:0]   cy,
    input  logic [Y_BITS-1:0]   dy,
    input  logic [PIX_BITS-1:0] in_pixel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [PIX_BITS-1:0] pixel_out,
    output logic [X_BITS-1:0]   pixel_x,
    output logic [Y_BITS-1:0]   pixel_y,
    output logic                pixel_out_flag,
    input  logic                out_ready,
    output logic                frame_done,
    output logic                busy
);

    localparam int XW = X_BITS + 2 + FRAC_BITS;
    localparam int YW = Y_BITS + 2 + FRAC_BITS;

    localparam logic signed [XW-1:0] XHALF = XW'(2 ** (FRAC_BITS - 1));
    localparam logic signed [YW-1:0] YHALF = YW'(2 ** (FRAC_BITS - 1));
    localparam logic signed [XW-1:0] XLIM  = XW'(SCREEN_W);
    localparam logic signed [YW-1:0] YLIM  = YW'(SCREEN_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_EDGE_STEP,
        S_LINE_SETUP,
        S_PIXEL,
        S_LINE_END,
        S_DONE
    } state_t;

    function automatic logic signed [XW-1:0] fx_x(input logic [X_BITS-1:0] v);
        return signed'({2'b00, v, {FRAC_BITS{1'b0}}});
    endfunction

    function automatic logic signed [YW-1:0] fx_y(input logic [Y_BITS-1:0] v);
        return signed'({2'b00, v, {FRAC_BITS{1'b0}}});
    endfunction

    state_t r_state;

    logic [X_BITS-1:0] r_ax, r_bx, r_cx, r_dx;
    logic [Y_BITS-1:0] r_ay, r_by, r_cy, r_dy;

    logic signed [XW-1:0] r_lx, r_rx, r_dlx, r_drx, r_px, r_dpx;
    logic signed [YW-1:0] r_ly, r_ry, r_dly, r_dry, r_py, r_dpy;

    logic [LOG2_W-1:0] r_col;
    logic [LOG2_H-1:0] r_row;

    logic [PIX_BITS-1:0] r_pix;
    logic [X_BITS-1:0]   r_pix_x;
    logic [Y_BITS-1:0]   r_pix_y;
    logic                r_out_flag;
    logic                r_frame_done;
    logic                r_busy;

    logic signed [XW-1:0] w_sum_x, w_rnd_x;
    logic signed [YW-1:0] w_sum_y, w_rnd_y;
    logic                 w_on_screen;
    logic                 w_accept;

    // Round to nearest integer pixel; the sign bit flags left/top clipping.
    assign w_sum_x = r_px + XHALF;
    assign w_sum_y = r_py + YHALF;
    assign w_rnd_x = w_sum_x >>> FRAC_BITS;
    assign w_rnd_y = w_sum_y >>> FRAC_BITS;

    assign w_on_screen = !w_rnd_x[XW-1] && (w_rnd_x < XLIM) &&
                         !w_rnd_y[YW-1] && (w_rnd_y < YLIM);

    assign in_ready = (r_state == S_PIXEL) && (!r_out_flag || out_ready);
    assign w_accept = in_valid && in_ready;

    assign pixel_out      = r_pix;
    assign pixel_x        = r_pix_x;
    assign pixel_y        = r_pix_y;
    assign pixel_out_flag = r_out_flag;
    assign frame_done     = r_frame_done;
    assign busy           = r_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_ax         <= '0;
            r_bx         <= '0;
            r_cx         <= '0;
            r_dx         <= '0;
            r_ay         <= '0;
            r_by         <= '0;
            r_cy         <= '0;
            r_dy         <= '0;
            r_lx         <= '0;
            r_rx         <= '0;
            r_dlx        <= '0;
            r_drx        <= '0;
            r_px         <= '0;
            r_dpx        <= '0;
            r_ly         <= '0;
            r_ry         <= '0;
            r_dly        <= '0;
            r_dry        <= '0;
            r_py         <= '0;
            r_dpy        <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_pix        <= '0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_out_flag   <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_out_flag && out_ready) begin
                r_out_flag <= 1'b0;
            end
            // A restart beats any handshake and drops the pending output.
            if (frame_start) begin
                r_state    <= S_LATCH;
                r_busy     <= 1'b1;
                r_out_flag <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_LATCH: begin
                        r_ax    <= ax;
                        r_bx    <= bx;
                        r_cx    <= cx;
                        r_dx    <= dx;
                        r_ay    <= ay;
                        r_by    <= by;
                        r_cy    <= cy;
                        r_dy    <= dy;
                        r_lx    <= fx_x(ax);
                        r_ly    <= fx_y(ay);
                        r_rx    <= fx_x(bx);
                        r_ry    <= fx_y(by);
                        r_row   <= '0;
                        r_state <= S_EDGE_STEP;
                    end
                    S_EDGE_STEP: begin
                        r_dlx   <= (fx_x(r_dx) - fx_x(r_ax)) >>> LOG2_H;
                        r_dly   <= (fx_y(r_dy) - fx_y(r_ay)) >>> LOG2_H;
                        r_drx   <= (fx_x(r_cx) - fx_x(r_bx)) >>> LOG2_H;
                        r_dry   <= (fx_y(r_cy) - fx_y(r_by)) >>> LOG2_H;
                        r_state <= S_LINE_SETUP;
                    end
                    S_LINE_SETUP: begin
                        r_dpx   <= (r_rx - r_lx) >>> LOG2_W;
                        r_dpy   <= (r_ry - r_ly) >>> LOG2_W;
                        r_px    <= r_lx;
                        r_py    <= r_ly;
                        r_col   <= '0;
                        r_state <= S_PIXEL;
                    end
                    S_PIXEL: begin
                        if (w_accept) begin
                            r_px  <= r_px + r_dpx;
                            r_py  <= r_py + r_dpy;
                            r_col <= r_col + 1'b1;
                            if (w_on_screen) begin
                                r_out_flag <= 1'b1;
                                r_pix      <= in_pixel;
                                r_pix_x    <= w_rnd_x[X_BITS-1:0];
                                r_pix_y    <= w_rnd_y[Y_BITS-1:0];
                            end
                            if (&r_col) begin
                                r_state <= S_LINE_END;
                            end
                        end
                    end
                    S_LINE_END: begin
                        r_lx  <= r_lx + r_dlx;
                        r_ly  <= r_ly + r_dly;
                        r_rx  <= r_rx + r_drx;
                        r_ry  <= r_ry + r_dry;
                        r_row <= r_row + 1'b1;
                        if (&r_row) begin
                            r_state      <= S_DONE;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state <= S_LINE_SETUP;
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
